// File: rtl/mem_copier.sv
// Memory initiator: copies LEN words SRC->DST, or fills DST with a constant,
// through a single-port Mem that writes on posedge clk and reads combinationally.
module mem_copier #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_val,
   output logic              busy,
   output logic              done,
   output logic              mem_w_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                mode_q, mode_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [DATA_W-1:0]   fill_q, fill_d;
   logic [ADDR_W:0]     idx_q, idx_d;
   logic [DATA_W-1:0]   buf_q, buf_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                w_en_q, w_en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [ADDR_W:0]     idx_nxt;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      idx_nxt = idx_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d = mode;
               src_d  = src;
               dst_d  = dst;
               len_d  = len;
               fill_d = fill_val;
               idx_d  = '0;
               if (len == '0)  state_d = S_DONE;
               else if (mode)  state_d = S_WR;
               else            state_d = S_RD;
            end
         end
         S_RD: begin
            buf_d   = mem_rdata;
            state_d = S_WR;
         end
         S_WR: begin
            idx_d = idx_nxt;
            if (idx_nxt == len_q) state_d = S_DONE;
            else if (mode_q)      state_d = S_WR;
            else                  state_d = S_RD;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so mem_w_en is a clean flop.
      busy_d = (state_d == S_RD) || (state_d == S_WR);
      done_d = (state_d == S_DONE);
      w_en_d = (state_d == S_WR);
      if (state_d == S_RD) begin
         addr_d = src_d + idx_d[ADDR_W-1:0];
      end else if (state_d == S_WR) begin
         addr_d  = dst_d + idx_d[ADDR_W-1:0];
         wdata_d = mode_d ? fill_d : buf_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         fill_q  <= '0;
         idx_q   <= '0;
         buf_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         w_en_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         w_en_q  <= w_en_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_w_en  = w_en_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_copier.sv
// Randomized scoreboard bench for mem_copier with a word-array Mem and a
// loop-based reference of the copy/fill semantics.
module tb_mem_copier;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int N  = 256;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [AW-1:0] src = '0;
   logic [AW-1:0] dst = '0;
   logic [AW:0]   len = '0;
   logic [DW-1:0] fill_val = '0;
   logic          busy, done, mem_w_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
      .len(len), .fill_val(fill_val), .busy(busy), .done(done), .mem_w_en(mem_w_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [N];
   logic [DW-1:0] ref_mem [N];
   logic          pk_en = 1'b0;
   logic [AW-1:0] pk_a = '0;
   logic [DW-1:0] pk_d = '0;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (pk_en)         mem[pk_a] <= pk_d;
      else if (mem_w_en) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {int busy; int wr;} exp_t;
   exp_t exp_q[$];
   int checks = 0, failures = 0;
   int done_seen = 0, target = 0;
   int busy_cnt = 0, wr_cnt = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic int mem_diff();
      int n = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   // Monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0;
         wr_cnt   = 0;
      end else begin
         if (busy)     busy_cnt++;
         if (mem_w_en) wr_cnt++;
         if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("busy_cycles", busy_cnt, e.busy);
               chk("write_count", wr_cnt, e.wr);
               chk("mem_image_diffs", mem_diff(), 0);
               chk("busy_in_done", busy, 0);
            end
            busy_cnt = 0;
            wr_cnt   = 0;
            done_seen++;
         end
      end
   end

   task automatic poke(input int a, input logic [DW-1:0] d);
      @(negedge clk);
      pk_en = 1'b1; pk_a = a[AW-1:0]; pk_d = d;
      ref_mem[a % N] = d;
      @(negedge clk);
      pk_en = 1'b0;
   endtask

   task automatic issue(input int m, input int s, input int d, input int l, input logic [DW-1:0] f);
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < l; i++) begin
         if (m != 0) ref_mem[(d + i) % N] = f;
         else        ref_mem[(d + i) % N] = ref_mem[(s + i) % N];
      end
      e.busy = (m != 0) ? l : 2 * l;
      e.wr   = l;
      exp_q.push_back(e);
      target = done_seen + 1;
      mode = m[0]; src = s[AW-1:0]; dst = d[AW-1:0]; len = l[AW:0]; fill_val = f;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 1'($urandom); src = AW'($urandom); dst = AW'($urandom);
      len = (AW+1)'($urandom); fill_val = $urandom;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_seen < target && n < 1200) begin
         @(negedge clk);
         n++;
      end
      chk("done_reached", done_seen >= target, 1);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_w_en"}, mem_w_en, 0);
      chk({nm, "_addr"}, mem_addr, 0);
      chk({nm, "_wdata"}, mem_wdata, 0);
   endtask

   initial begin
      #1;
      chk_zero("reset");
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         pk_en = 1'b1; pk_a = i[AW-1:0]; pk_d = $urandom;
         ref_mem[i] = pk_d;
      end
      @(negedge clk);
      pk_en = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("preload_diffs", mem_diff(), 0);

      // Basic copy
      poke(1, 32'h12345678);
      poke(2, 32'h87654321);
      issue(0, 1, 10, 2, 32'h0);
      wait_done();
      chk("copy_mem10", mem[10], 32'h12345678);
      chk("copy_mem11", mem[11], 32'h87654321);

      // Wrapping fill
      issue(1, 0, 250, 10, 32'hDEADBEEF);
      wait_done();
      chk("fill_wrap_mem3", mem[3], 32'hDEADBEEF);
      chk("fill_wrap_mem255", mem[255], 32'hDEADBEEF);

      // Zero length
      issue(0, 5, 6, 0, 32'h0);
      wait_done();

      // Forward smear overlap
      poke(0, 32'hA); poke(1, 32'hB); poke(2, 32'hC); poke(3, 32'hD);
      issue(0, 0, 1, 3, 32'h0);
      wait_done();
      chk("smear_mem3", mem[3], 32'hA);

      // Reset after the second write of a len=5 fill
      @(negedge clk);
      mode = 1'b1; dst = 8'd100; len = 9'd5; fill_val = 32'hCAFEF00D; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ref_mem[100] = 32'hCAFEF00D;
      ref_mem[101] = 32'hCAFEF00D;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("abort");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_mem_diffs", mem_diff(), 0);
      chk("abort_no_done", done_seen, target);

      issue(1, 0, 100, 5, 32'h0BADC0DE);
      wait_done();

      // Start pulse while busy must be ignored
      issue(0, 20, 40, 6, 32'h0);
      @(negedge clk); @(negedge clk);
      mode = 1'b1; src = 8'd7; dst = 8'd41; len = 9'd9; fill_val = 32'h55555555; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Full address space
      issue(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 256, $urandom);
      wait_done();

      for (int k = 0; k < 20; k++) begin
         issue(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 40)), $urandom);
         wait_done();
      end

      repeat (20) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
